ram_dp_be_clear: RTL
====================

# ram_dp_be_clear

Parametrised simple dual-port RAM: one write port with byte enables, one registered read port with a selectable read-during-write mode, and a hardware clear sequencer. The sequencer fills every location with a fixed value after reset or on request. It is the successor to the asynchronous-read dual-port RAM and serves as the general buffer/table memory in the datapath. Software and upstream logic must watch `busy` before trusting contents.

## Interface
Parameters:
- `WIDTH`, 32: data word width; must be a multiple of `BYTE_W`.
- `DEPTH`, 16: number of words; need not be a power of two.
- `DEPTH_LOG`, `$clog2(DEPTH)`: address width.
- `BYTE_W`, 8: bits per byte-enable lane; lanes = `WIDTH/BYTE_W`.
- `RDW_MODE`, 0: same-address read-during-write behaviour; 0 = read-first (old data), 1 = write-first (new merged data).
- `CLEAR_ON_RESET`, 1: 1 = clear sequence starts automatically when reset releases.
- `CLEAR_VAL`, 0: `WIDTH`-bit value written to every word by the clear sequence.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `clr` in 1: single-cycle clear request.
- `busy` out 1: high while the clear sequence runs.
- `we` in 1: write enable, active-high.
- `wr_be` in `WIDTH/BYTE_W`: per-lane write enable.
- `wr_addr` in `DEPTH_LOG`: write address.
- `wr_data` in `WIDTH`: write data.
- `rd_en` in 1: read enable.
- `rd_addr` in `DEPTH_LOG`: read address.
- `rd_data` out `WIDTH`: registered read data.
- `rd_valid` out 1: `rd_data` updated this cycle.

## Operation
- **Storage:** array of `DEPTH` x `WIDTH`. The array is not reset; only control registers are.
- **Write:** when `we`=1, not busy, and `wr_addr`<`DEPTH`, each lane i with `wr_be[i]`=1 takes `wr_data` lane i. Other lanes keep their value. `wr_be`=0 means no change.
- **Out-of-range write:** `wr_addr`>=`DEPTH` is ignored, with no aliasing.
- **Read:** when `rd_en`=1 and not busy, `rd_data` loads `ram[rd_addr]` at the edge. An out-of-range `rd_addr` loads all-zero. `rd_data` holds its value when `rd_en`=0.
- **Read-during-write, same in-range address, same edge:**
  - `RDW_MODE`=0: `rd_data` = word before the write.
  - `RDW_MODE`=1: `rd_data` = post-write word, i.e. enabled lanes from `wr_data`, other lanes old.
- **Clear FSM, states IDLE and CLEAR:**
  - Reset forces CLEAR if `CLEAR_ON_RESET`=1, otherwise IDLE. The address counter resets to 0.
  - IDLE -> CLEAR when `clr`=1; counter <= 0.
  - In CLEAR: write `CLEAR_VAL` to `ram[counter]` and increment each cycle. After writing `DEPTH-1`, go to IDLE.
  - `busy` = (state == CLEAR), a registered output.
- **While busy:**
  - `we` and `rd_en` are ignored; `rd_valid` stays 0 and `rd_data` holds.
  - `clr` is ignored; it does not restart the sequence.
- **`clr` and `we`/`rd_en` in the same IDLE cycle:** the access is performed that cycle. Clearing starts the next cycle and will overwrite the write.
- **Reset mid-clear:** the sequence aborts. After release it restarts from address 0 if `CLEAR_ON_RESET`=1, otherwise contents are undefined and state is IDLE.

## Timing
- **Reset values:**
  - `rd_data`=0, `rd_valid`=0.
  - `busy`=`CLEAR_ON_RESET`.
- **Read latency:** 1 cycle. `rd_en` sampled at edge N gives `rd_data` and `rd_valid`=1 after edge N. `rd_valid` is high for exactly one cycle per accepted read.
- **Write latency:** a write at edge N is visible to a read sampled at edge N+1, and at edge N itself per `RDW_MODE`.
- **Clear duration:** `busy` is high for exactly `DEPTH` cycles.
  - Auto-clear: high from reset release through the edge that writes `DEPTH-1`.
  - `clr` sampled at edge N: `busy` rises after N and falls after edge N+`DEPTH`.
  - The first accepted access is at edge N+`DEPTH`+1.
- **Throughput:** one write and one read per cycle, independent addresses.

## Test plan
- **Auto-clear:** `WIDTH`=32, `DEPTH`=16, `CLEAR_VAL`=32'hA5A5A5A5; release reset and count busy cycles -> `busy` high 16 cycles, then reads of all 16 addresses return A5A5A5A5 with `rd_valid` one cycle after each `rd_en`.
- **Byte enables:** write 32'h11223344 to addr 3 with `wr_be`=4'b1111, then 32'hFFFFFFFF with `wr_be`=4'b0101 -> read addr 3 returns 32'h11FF33FF.
- **Read-during-write:** addr 5 holds 32'h0; write 32'hDEADBEEF to addr 5 with `wr_be`=4'b1111 while reading addr 5 on the same edge -> `RDW_MODE`=0 returns 32'h0, `RDW_MODE`=1 returns 32'hDEADBEEF.
- **Accesses while busy:** pulse `clr`, then during busy issue a write to addr 2, `rd_en`, and a second `clr` -> `rd_valid` stays 0, `busy` falls exactly 16 cycles after the first `clr`, addr 2 reads `CLEAR_VAL`.
- **Non-power-of-two depth:** `DEPTH`=12; write addr 13 and read addr 14 -> addr 1 (the alias of 13) is unchanged, read returns 0 with `rd_valid`=1, and clear takes 12 cycles.
- **Reset mid-clear:** assert `rst_n`=0 at clear cycle 7 -> `busy` remains 1 (`CLEAR_ON_RESET`=1), `rd_data`=0, and after release a full 16-cycle clear completes with all words equal to `CLEAR_VAL`.

Source files
------------

// File: rtl/ram_dp_be_clear.sv
// ============================================================================
// ram_dp_be_clear : simple dual-port RAM, byte-enable write, registered read,
//                   hardware clear sequencer (fills every word with CLEAR_VAL)
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_dp_be_clear #(
   parameter int                WIDTH          = 32,
   parameter int                DEPTH          = 16,
   parameter int                DEPTH_LOG      = $clog2(DEPTH),
   parameter int                BYTE_W         = 8,
   parameter int                RDW_MODE       = 0,
   parameter int                CLEAR_ON_RESET = 1,
   parameter logic [WIDTH-1:0]  CLEAR_VAL      = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   output logic                      busy,
   input  logic                      we,
   input  logic [WIDTH/BYTE_W-1:0]   wr_be,
   input  logic [DEPTH_LOG-1:0]      wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      rd_en,
   input  logic [DEPTH_LOG-1:0]      rd_addr,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      rd_valid
);

   localparam int                   LANES     = WIDTH / BYTE_W;
   localparam logic [DEPTH_LOG:0]   DEPTH_C   = (DEPTH_LOG+1)'(DEPTH);
   localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

   state_t               state_q, state_d;
   logic [DEPTH_LOG-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]     rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;

   logic [WIDTH-1:0]     mem [DEPTH];

   logic                 busy_int;
   logic                 wr_in_range, rd_in_range;
   logic                 wr_ok, rd_ok;
   logic [DEPTH_LOG-1:0] wr_idx, rd_idx;
   logic [WIDTH-1:0]     old_word, merged_word;
   logic                 mem_we;
   logic [DEPTH_LOG-1:0] mem_addr;
   logic [WIDTH-1:0]     mem_wdata;

   assign busy_int    = (state_q == ST_CLEAR);
   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
   assign wr_ok       = we & ~busy_int & wr_in_range;
   assign rd_ok       = rd_en & ~busy_int;

   // Out-of-range addresses are steered to word 0 only to keep array reads
   // in bounds; the qualifying enables stop them from having any effect.
   assign wr_idx   = wr_in_range ? wr_addr : '0;
   assign rd_idx   = rd_in_range ? rd_addr : '0;
   assign old_word = mem[wr_idx];

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign merged_word[i*BYTE_W +: BYTE_W] = wr_be[i] ? wr_data[i*BYTE_W +: BYTE_W]
                                                        : old_word[i*BYTE_W +: BYTE_W];
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = wr_idx;
      mem_wdata = merged_word;
      if (busy_int) begin
         mem_we    = 1'b1;
         mem_addr  = cnt_q;
         mem_wdata = CLEAR_VAL;
      end else if (wr_ok) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clr) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_ok;
      if (rd_ok) begin
         if (!rd_in_range) begin
            rd_data_d = '0;
         end else if ((RDW_MODE == 1) && wr_ok && (wr_addr == rd_addr)) begin
            rd_data_d = merged_word;
         end else begin
            rd_data_d = mem[rd_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RESET_STATE;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign busy     = busy_int;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

`default_nettype wire
